stimulus_arbiter: RTL

Schedules pet-care stimuli into the tamagotchi state machine one at a time. Four stimulus sources are latched independently: heal button, feed button, MPU6050 tilt, and ultrasonic presence. The block grants them in round-robin order over a valid/ready handshake. After each accepted grant it enforces a cooldown so a noisy sensor cannot flood the FSM, and it reports pending and dropped stimuli for debug LEDs.

---
 rtl/stimulus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stimulus_arbiter.sv
// Round-robin arbiter that feeds latched pet-care stimuli to the tamagotchi FSM one at a time,
// with a post-grant cooldown and debug counters for pending and lost requests.
module stimulus_arbiter #(
   parameter int COOL_MAX = 25000000,
   parameter int CNT_W    = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_in,
   input  logic       test_mode,
   output logic       grant_valid,
   output logic [1:0] grant_id,
   input  logic       grant_ready,
   output logic [3:0] pending,
   output logic       busy,
   output logic [7:0] dropped
);

   typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

   localparam logic [CNT_W-1:0] COOL_LOAD = (COOL_MAX > 0) ? CNT_W'(COOL_MAX - 1) : '0;
   localparam bit               SKIP_COOL = (COOL_MAX == 0);

   state_t           state_q, state_d;
   logic [3:0]       req_prev_q;
   logic             armed_q;
   logic [3:0]       pending_q, pending_d;
   logic             valid_q, valid_d;
   logic [1:0]       id_q, id_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q;
   logic [7:0]       drop_q, drop_d;

   logic [3:0]       rise, clr, lost;
   logic             handshake;
   logic [1:0]       pick, idx;
   logic             found;
   logic [2:0]       nlost;
   logic [8:0]       dsum;

   // armed_q keeps a level already high at reset release from looking like an edge
   assign rise      = armed_q ? (req_in & ~req_prev_q) : 4'b0000;
   assign handshake = valid_q & grant_ready;
   assign clr       = handshake ? (4'b0001 << id_q) : 4'b0000;
   // A rise on the source being cleared re-arms it instead of counting as lost
   assign lost      = rise & pending_q & ~clr;
   assign pending_d = (pending_q & ~clr) | rise;
   assign nlost     = {2'b00, lost[0]} + {2'b00, lost[1]} + {2'b00, lost[2]} + {2'b00, lost[3]};
   assign dsum      = {1'b0, drop_q} + {6'b000000, nlost};
   assign drop_d    = dsum[8] ? 8'hFF : dsum[7:0];

   always_comb begin
      pick  = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && pending_q[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               id_d    = pick;
               valid_d = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (handshake) begin
               valid_d = 1'b0;
               last_d  = id_q;
               if (test_mode || SKIP_COOL) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = COOL_LOAD;
                  state_d = COOLDOWN;
               end
            end
         end
         COOLDOWN: begin
            if (test_mode || (cnt_q == '0)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_prev_q <= 4'b0000;
         armed_q    <= 1'b0;
         pending_q  <= 4'b0000;
         valid_q    <= 1'b0;
         id_q       <= 2'd0;
         last_q     <= 2'd3;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         drop_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= req_in;
         armed_q    <= 1'b1;
         pending_q  <= pending_d;
         valid_q    <= valid_d;
         id_q       <= id_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         busy_q     <= (state_d != IDLE);
         drop_q     <= drop_d;
      end
   end

   assign grant_valid = valid_q;
   assign grant_id    = id_q;
   assign pending     = pending_q;
   assign busy        = busy_q;
   assign dropped     = drop_q;

endmodule
